// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared types for the MEM-stage branch/jump resolution slice.
//   mem_state_e   : redirect FSM states (IDLE, REDIRECT)
//   ex_mem_t      : EX/MEM stage register contents (control fields + target)
//   EX_MEM_BUBBLE : all-zero stage register contents (no instruction)
//   is_taken()    : resolves a stage register entry against not-taken fetch
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic                valid;
        logic                jump;
        logic                branch;
        logic                inverse_branch;
        logic                zero;
        logic [XLEN_DEF-1:0] target;
    } ex_mem_t;

    localparam ex_mem_t EX_MEM_BUBBLE = '0;

    // Fetch always predicts not-taken, so any taken jump/branch is a
    // misprediction. A jump wins over a branch flag if both are set.
    function automatic logic is_taken(input ex_mem_t m);
        return m.valid & (m.jump | (m.branch & (m.zero ^ m.inverse_branch)));
    endfunction

endpackage

// File: rtl/mem_branch_resolve_if.sv
// ---------------------------------------------------------------------------
// mem_branch_resolve_if
// Bundles the EX->MEM control fields and the MEM->fetch redirect handshake.
//   ex_valid/ex_jump/ex_branch/ex_inverse_branch/ex_zero/ex_target : EX side
//   redirect_valid/redirect_pc : redirect request towards fetch
//   redirect_ready             : fetch accepts the redirect
// Modports:
//   master : EX stage + fetch side (drives ex_* and redirect_ready)
//   slave  : the resolution unit (drives redirect_valid/redirect_pc)
// ---------------------------------------------------------------------------
interface mem_branch_resolve_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_jump;
    logic            ex_branch;
    logic            ex_inverse_branch;
    logic            ex_zero;
    logic [XLEN-1:0] ex_target;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (
        output ex_valid, ex_jump, ex_branch, ex_inverse_branch, ex_zero,
               ex_target, redirect_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  ex_valid, ex_jump, ex_branch, ex_inverse_branch, ex_zero,
               ex_target, redirect_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
// EX/MEM stage register with flush > stall > fire > load priority.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_flush    : external flush, loads a bubble
//   i_stall    : hold current contents
//   i_fire     : a taken branch resolves this cycle; the EX instruction is
//                younger than it, so a bubble is loaded instead
//   i_d        : EX stage fields
//   o_q        : registered MEM stage fields
// ---------------------------------------------------------------------------
module ex_mem_reg
    import mem_stage_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_flush,
    input  logic    i_stall,
    input  logic    i_fire,
    input  ex_mem_t i_d,
    output ex_mem_t o_q
);

    ex_mem_t r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= EX_MEM_BUBBLE;
        end else if (i_flush) begin
            r_q <= EX_MEM_BUBBLE;
        end else if (i_stall) begin
            r_q <= r_q;
        end else if (i_fire) begin
            r_q <= EX_MEM_BUBBLE;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_branch_resolve.sv
// ---------------------------------------------------------------------------
// mem_branch_resolve
// MEM-stage branch/jump resolution against a static not-taken fetch policy.
// A taken branch/jump squashes younger stages (flush_o) and raises a
// registered redirect request that is held until fetch accepts it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : EX fields in, redirect_valid/redirect_pc out,
//                         redirect_ready in
//   stall_i             : downstream stall, holds the stage register
//   flush_i             : external trap flush, highest priority
//   flush_o             : squash IF/ID and ID/EX (combinational, = fire)
//   stall_o             : freeze upstream while a redirect is pending
//   branch_cnt          : resolved conditional branches (wraps)
//   taken_cnt           : redirects issued (wraps)
// ---------------------------------------------------------------------------
module mem_branch_resolve
    import mem_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_branch_resolve_if.slave    bus,
    input  logic                   stall_i,
    input  logic                   flush_i,
    output logic                   flush_o,
    output logic                   stall_o,
    output logic [CNT_W-1:0]       branch_cnt,
    output logic [CNT_W-1:0]       taken_cnt
);

    ex_mem_t    w_ex;
    ex_mem_t    w_m;
    logic       w_idle;
    logic       w_taken;
    logic       w_fire;
    logic       w_branch_res;

    mem_state_e       r_state;
    logic             r_redirect_valid;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    always_comb begin
        w_ex                = EX_MEM_BUBBLE;
        w_ex.valid          = bus.ex_valid;
        w_ex.jump           = bus.ex_jump;
        w_ex.branch         = bus.ex_branch;
        w_ex.inverse_branch = bus.ex_inverse_branch;
        w_ex.zero           = bus.ex_zero;
        w_ex.target         = bus.ex_target;
    end

    ex_mem_reg u_ex_mem_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush_i),
        .i_stall (stall_i),
        .i_fire  (w_fire),
        .i_d     (w_ex),
        .o_q     (w_m)
    );

    assign w_idle  = (r_state == IDLE);
    assign w_taken = is_taken(w_m);

    // Resolution happens only in an unstalled, unflushed IDLE cycle, so a
    // branch held under stall is resolved (and counted) exactly once.
    assign w_fire       = w_taken & ~stall_i & ~flush_i & w_idle;
    assign w_branch_res = w_m.valid & w_m.branch & ~w_m.jump
                          & ~stall_i & ~flush_i & w_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        r_state          <= REDIRECT;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= w_m.target[XLEN-1:0];
                    end
                end
                REDIRECT: begin
                    // A trap flush takes fetch over, so the pending redirect
                    // is dropped just like an accepted one.
                    if (flush_i || bus.redirect_ready) begin
                        r_state          <= IDLE;
                        r_redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= IDLE;
                    r_redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            if (w_branch_res) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_fire) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
        end
    end

    assign flush_o            = w_fire;
    assign stall_o            = (r_state == REDIRECT);
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign branch_cnt         = r_branch_cnt;
    assign taken_cnt          = r_taken_cnt;

endmodule

// File: doc/mem_branch_resolve.md
Name: mem_branch_resolve

Overview:
MEM-stage branch/jump resolution unit, directly downstream of the EX stage. It carries the EX/MEM control fields (Jump, Branch, InverseBranch, zero flag, target) in its own stage register and resolves them against a static not-taken fetch policy. On a taken branch or jump it squashes younger instructions and holds a redirect request to fetch until fetch accepts it. It also keeps branch and redirect statistics counters.

Parameters:
XLEN, 32, width of PC and target
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX stage holds a real instruction
ex_jump  in  1  unconditional jump
ex_branch  in  1  conditional branch
ex_inverse_branch  in  1  invert branch condition; meaningful only when ex_branch=1
ex_zero  in  1  ALU zero flag of the comparison
ex_target  in  XLEN  computed branch/jump target
stall_i  in  1  hold the stage register (downstream stall)
flush_i  in  1  external flush (trap), highest priority
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  XLEN  redirect target
redirect_ready  in  1  fetch accepts the redirect
flush_o  out  1  squash IF/ID and ID/EX this cycle
stall_o  out  1  freeze upstream stages while a redirect is pending
branch_cnt  out  CNT_W  resolved conditional branches
taken_cnt  out  CNT_W  redirects issued

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: stage register is a bubble (m_valid=0, all fields 0); state=IDLE; redirect_valid=0, redirect_pc=0, flush_o=0, stall_o=0; both counters 0.
- Stage register update, each posedge, in priority order:
  - flush_i=1: load bubble.
  - stall_i=1: hold.
  - fire=1: load bubble, because the EX instruction is younger than the taken branch.
  - Otherwise: load the ex_* fields.
- taken = m_valid & (m_jump | (m_branch & (m_zero ^ m_inverse_branch))).
- fire = taken & ~stall_i & ~flush_i & (state==IDLE).
- The Jump and Branch fields are never both 1. If they are, Jump wins and the instruction is counted as a jump only.
- flush_o is combinational and equals fire. It is a one-cycle pulse in the resolve cycle.
- State machine:
  - IDLE: on fire, latch redirect_pc<=m_target and go to REDIRECT. Otherwise stay.
  - REDIRECT: redirect_valid=1 and stall_o=1.
    - redirect_ready=1: go to IDLE. redirect_valid is 0 on the next cycle.
    - redirect_ready=0: hold. redirect_pc must stay stable.
    - flush_i=1: go to IDLE and drop the redirect. The trap path owns fetch.
- Latency: branch in MEM at cycle N → flush_o at N → redirect_valid at N+1. The earliest return to IDLE is N+2 (ready at N+1).
- redirect_valid and redirect_pc are registered outputs. stall_o = (state==REDIRECT).
- Counters:
  - branch_cnt += 1 on each cycle where m_valid & m_branch & ~m_jump & ~stall_i & ~flush_i & (state==IDLE), whether taken or not.
  - taken_cnt += 1 on fire.
  - Both counters wrap modulo 2^CNT_W, with no saturation.
- Boundary conditions:
  - stall_i during a taken branch: no fire, no count. The branch resolves exactly once, on the first unstalled cycle.
  - flush_i together with taken: flush wins. No redirect, no count, stage register loads a bubble.
  - A taken instruction in the stage register while in REDIRECT cannot occur, because upstream is stalled and the register holds a bubble. If it occurs anyway, it is not fired until the FSM returns to IDLE.
  - Reset asserted mid-REDIRECT: the FSM returns to IDLE immediately (asynchronously), and redirect_valid and stall_o go to 0.

Decomposition:
- Package mem_stage_pkg:
  - mem_state_e {IDLE, REDIRECT}.
  - ex_mem_t packed struct {valid, jump, branch, inverse_branch, zero, target}.
  - EX_MEM_BUBBLE constant.
- One sub-module, ex_mem_reg: the stage register with flush/stall/bubble priority. Resolution, FSM and counters stay in the top.

Test Plan:
- Not-taken branch: ex_branch=1, zero=0, inverse=0 → no flush_o, redirect_valid stays 0, branch_cnt=1, taken_cnt=0.
- Taken inverse branch: ex_branch=1, zero=0, inverse=1, target=0x100, redirect_ready tied 1 → flush_o pulses one cycle; next cycle redirect_valid=1 with redirect_pc=0x100; state back to IDLE after that; branch_cnt=1, taken_cnt=1.
- Jump with fetch backpressure: ex_jump=1, target=0x2000, redirect_ready=0 for 3 cycles → redirect_valid and stall_o high for 4 cycles with redirect_pc stable at 0x2000; both drop the cycle after ready; branch_cnt=0, taken_cnt=1.
- Stall during taken branch: stall_i=1 for 2 cycles with a taken branch held in the stage → exactly one flush_o pulse after the stall releases; taken_cnt=1.
- Priority and reset: flush_i coincident with a taken jump → no redirect and taken_cnt=0. Separately, rst_n asserted low mid-REDIRECT → redirect_valid=0 immediately, state IDLE, counters 0.
- Counter wrap: CNT_W=4, 17 taken jumps → taken_cnt=1.
